mux2_sel_ctrl: RTL

Registered select controller that drives the `sel` input of the downstream 2:1 data mux (`mux2`). It arbitrates between two requesting sources with round-robin fairness and enforces a minimum dwell time per grant. On every switchover it inserts a programmable dead gap, so the mux output settles before the consumer sees `grant_valid`. It also keeps a saturating count of completed switchovers for debug and timing-closure benches.

---
 rtl/mux2_sel_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mux2_sel_ctrl.sv
// Registered select controller for a downstream 2:1 mux: round-robin arbitration
// with a minimum dwell per grant and a programmable dead gap on each switchover.
module mux2_sel_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_0,
  input  logic       req_1,
  output logic       sel,
  output logic       grant_valid,
  output logic       switching,
  output logic [7:0] sw_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    SWITCH = 2'd3
  } state_e;

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [3:0] GAP_LD   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       gv_q, gv_d;
  logic       sw_q, sw_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] gap_q, gap_d;

  logic       own_req;
  logic       oth_req;
  logic [7:0] cnt_inc;

  // In GRANTx sel_q names the owner; in SWITCH it already names the target.
  assign own_req = sel_q ? req_1 : req_0;
  assign oth_req = sel_q ? req_0 : req_1;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_0) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
          dwell_d = DWELL_LD;
        end else if (req_1) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
          dwell_d = DWELL_LD;
        end
      end
      GRANT0, GRANT1: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 8'd1;
        end else if (oth_req) begin
          sel_d = ~sel_q;
          if (GAP == 0) begin
            state_d = sel_q ? GRANT0 : GRANT1;
            dwell_d = DWELL_LD;
            cnt_d   = cnt_inc;
          end else begin
            state_d = SWITCH;
            gap_d   = GAP_LD;
          end
        end else if (!own_req) begin
          state_d = IDLE;
        end
      end
      SWITCH: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 4'd1;
        end else if (own_req) begin
          state_d = sel_q ? GRANT1 : GRANT0;
          dwell_d = DWELL_LD;
          cnt_d   = cnt_inc;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gv_d = (state_d == GRANT0) || (state_d == GRANT1);
    sw_d = (state_d == SWITCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      gv_q    <= 1'b0;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gv_q    <= gv_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign sel         = sel_q;
  assign grant_valid = gv_q;
  assign switching   = sw_q;
  assign sw_count    = cnt_q;

endmodule
